// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: word width, canonical NOP and the queued
// {pc, instr, misaligned} entry that decode also consumes.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one
// asynchronous read port, contents intentionally left unreset.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  fetch_entry_t        wdata,
  input  logic [AW-1:0]       raddr,
  output fetch_entry_t        rdata
);

  fetch_entry_t mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with valid/ready on both sides and a
// flush that drops every buffered entry on a taken branch.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = fetch_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  output logic                       out_misaligned,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  fetch_entry_t  wr_entry;
  fetch_entry_t  rd_entry;

  // in_ready looks only at occupancy, so a full queue never accepts on a same-cycle pop
  assign in_ready  = (count != CNT_FULL);
  assign out_valid = (count != {CW{1'b0}});
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign wr_entry.pc         = in_pc;
  assign wr_entry.instr      = in_instr;
  assign wr_entry.misaligned = (in_pc[1:0] != 2'b00);

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Pointer and occupancy state; flush outranks push and pop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Head presentation, zeroed while empty so stale storage never leaks
  always_comb begin
    out_pc         = {XLEN{1'b0}};
    out_instr      = {XLEN{1'b0}};
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_pc         = rd_entry.pc;
      out_instr      = rd_entry.instr;
      out_misaligned = rd_entry.misaligned;
    end else begin
      out_pc         = {XLEN{1'b0}};
      out_instr      = {XLEN{1'b0}};
      out_misaligned = 1'b0;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the fetch stage (PC register plus instruction memory read) and the decode stage. It captures {pc, instruction} pairs returned by fetch in a small circular FIFO and presents them in order to decode with a valid/ready handshake. It drops all buffered entries on a taken branch. `in_ready` back-pressures fetch so the PC advance can be gated when the queue is full.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `XLEN`, 32: width of PC and instruction words.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents a pc/instruction pair this cycle.
- `in_pc`  in  XLEN  address of the fetched instruction.
- `in_instr`  in  XLEN  fetched instruction word.
- `in_ready`  out  1  queue can accept a push this cycle.
- `flush`  in  1  taken branch (`br_taken`); discard all entries.
- `out_valid`  out  1  head entry available to decode.
- `out_pc`  out  XLEN  PC of head entry.
- `out_instr`  out  XLEN  instruction of head entry.
- `out_misaligned`  out  1  head entry's PC has `[1:0] != 0`.
- `out_ready`  in  1  decode consumes the head this cycle.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage is a circular array of DEPTH entries {pc, instr, misaligned}, with a write pointer `wr_ptr`, a read pointer `rd_ptr` and an occupancy register `count`.
  - Each pointer is $clog2(DEPTH) bits wide and wraps modulo DEPTH with no special case.
- `misaligned` is computed from `in_pc[1:0]` at push time and stored with the entry.
- `in_ready = (count != DEPTH)`. It is decoded from registered state only and never depends on `out_ready`.
- `out_valid = (count != 0)`.
- While `out_valid` is 1, `out_pc`, `out_instr` and `out_misaligned` show entry[`rd_ptr`]. While `out_valid` is 0, all three are 0.
- A push occurs when `in_valid && in_ready && !flush`: the entry is written at `wr_ptr`, then `wr_ptr` increments.
- A pop occurs when `out_valid && out_ready && !flush`: `rd_ptr` increments.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged.
- Only push: `count` + 1. Only pop: `count` − 1.
- Flush has priority over everything. On the next edge `wr_ptr`, `rd_ptr` and `count` become 0. The same-cycle push is discarded and no pop is counted.
- A full queue does not accept a push, even when a pop occurs in the same cycle. The freed slot becomes available the following cycle.
- `in_valid` with `in_ready` = 0 is not an error. The producer holds its data and the queue ignores it.

## Timing
- Reset (asynchronous, takes effect immediately): pointers and `count` = 0, `in_ready` = 1, `out_valid` = 0, `out_pc` = `out_instr` = 0, `out_misaligned` = 0. Storage contents are not reset.
- Push-to-output latency is 1 cycle. An entry pushed at edge N is visible on `out_*` after edge N. There is no combinational bypass from `in_*` to `out_*`.
- Pop takes effect at the edge. The next entry, or zeros if the queue is now empty, appears immediately after that edge.
- After a flush at edge N: `out_valid` = 0 and `in_ready` = 1 from edge N onward. A push is accepted at edge N+1.
- Reset asserted mid-operation: the queue returns to the reset state asynchronously. A handshake in progress is lost.
- All outputs are decoded from registers. There is no combinational path from any input to any output.

## Structure
- The shared package `fetch_pkg` holds:
  - `XLEN`;
  - `INSTR_NOP` = 32'h00000013;
  - the `fetch_entry_t` struct {pc, instr, misaligned}, which decode reuses.
- One sub-module is natural: `fetch_queue_mem`, a DEPTH × `fetch_entry_t` register array with one write port and one asynchronous read port. It has no reset.
- Pointer, count and flush control stay in `fetch_queue`.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-cycle -> `out_valid` = 0, `in_ready` = 1, `count` = 0 immediately; `out_pc` = 0.
- **Single pass:** push {0x00000000, 0x00000013} with `out_ready` = 0 -> next cycle `out_valid` = 1, `out_pc` = 0x0, `out_instr` = 0x13, `count` = 1; then pulse `out_ready` -> `count` = 0, `out_valid` = 0.
- **Fill and wrap:** push PCs 0x0, 0x4, 0x8, 0xC with `out_ready` = 0 -> `count` = 4, `in_ready` = 0, and a fifth push of 0x10 is ignored. Then pop one and push 0x10, repeating until 8 entries have been pushed -> pops return 0x0, 0x4, …, 0x1C in order across the pointer wrap.
- **Full with simultaneous pop:** at `count` = 4, `in_valid` = 1 and `out_ready` = 1 -> `count` = 3 next cycle and the offered entry is not stored; it is accepted the following cycle with `count` back at 4.
- **Flush priority:** `count` = 2 with `flush`, `in_valid` and `out_ready` all 1 in the same cycle -> next cycle `count` = 0, `out_valid` = 0, `in_ready` = 1; a subsequent push of 0x100 is the head.
- **Misaligned tag:** push `in_pc` = 0x00000006 -> `out_misaligned` = 1 when that entry is at the head; an aligned entry behind it shows 0.
